// File: rtl/brick_scan_controller.sv
// Brick-collision scan sequencer: clears and runs the brick scanner once per frame, latches the first hit,
// writes the downgraded brick back and tracks how many bricks remain. Optional scoring via `SCORE_EN.
`timescale 1ns/1ps
module brick_scan_controller #(
  parameter logic [7:0] SCAN_TIMEOUT = 8'd200,
  parameter logic [7:0] PTS_NORMAL   = 8'd1,
  parameter logic [7:0] PTS_STRONG   = 8'd2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        frame_tick,
  output logic        ballcheckEnable,
  output logic        ballcheckReset,
  input  logic        ballcheckEnd,
  input  logic        brickBallCollide,
  input  logic [2:0]  collideDir,
  input  logic [3:0]  brick_x,
  input  logic [3:0]  brick_y,
  input  logic [3:0]  brick_type,
  output logic        wr_en,
  output logic [3:0]  wr_x,
  output logic [3:0]  wr_y,
  output logic [3:0]  wr_type,
  output logic        hit_valid,
  output logic [2:0]  hit_dir,
  output logic        scan_done,
  output logic        scan_err,
  output logic        level_clear,
  output logic        overrun,
  output logic [15:0] score
);

  typedef enum logic [2:0] {IDLE, CLR, SCAN, WR, DONE} state_t;

  state_t      state_reg, state_next;
  logic        bcr_reg, hit_reg, err_reg, lc_reg;
  logic [6:0]  cnt_reg;
  logic [7:0]  tmo_reg;
  logic [3:0]  lat_x_reg, lat_y_reg, lat_type_reg;
  logic [2:0]  lat_dir_reg;
  logic        timeout_c, destroyed_c;
  logic [3:0]  wr_type_c;
  logic [6:0]  remaining_c;

  always_comb begin
    timeout_c = !ballcheckEnd && (tmo_reg == SCAN_TIMEOUT - 8'd1);
    case (lat_type_reg)
      4'd3:    wr_type_c = 4'd1;
      4'd4:    wr_type_c = 4'd2;
      default: wr_type_c = 4'd0;
    endcase
    // Only a counted brick (nonzero type) that gets wiped reduces the remaining count
    destroyed_c = hit_reg && (wr_type_c == 4'd0) && (lat_type_reg != 4'd0);
    remaining_c = cnt_reg - {6'd0, destroyed_c};
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (frame_tick) state_next = CLR;
      CLR:  state_next = SCAN;
      SCAN: begin
        if (ballcheckEnd)   state_next = WR;
        else if (timeout_c) state_next = DONE;
      end
      WR:      state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg    <= IDLE;
      bcr_reg      <= 1'b1;
      hit_reg      <= 1'b0;
      err_reg      <= 1'b0;
      lc_reg       <= 1'b0;
      cnt_reg      <= 7'd0;
      tmo_reg      <= 8'd0;
      lat_x_reg    <= 4'd0;
      lat_y_reg    <= 4'd0;
      lat_type_reg <= 4'd0;
      lat_dir_reg  <= 3'd0;
    end else begin
      state_reg <= state_next;
      bcr_reg   <= (state_next == CLR);
      if (state_reg == IDLE && frame_tick)
        lc_reg <= 1'b0;
      if (state_reg == CLR) begin
        hit_reg <= 1'b0;
        err_reg <= 1'b0;
        cnt_reg <= 7'd0;
        tmo_reg <= 8'd0;
      end
      if (state_reg == SCAN) begin
        tmo_reg <= tmo_reg + 8'd1;
        if (brick_x != 4'hF && brick_type != 4'd0 && cnt_reg != 7'h7F)
          cnt_reg <= cnt_reg + 7'd1;
        if (brickBallCollide && !hit_reg) begin
          hit_reg      <= 1'b1;
          lat_x_reg    <= brick_x;
          lat_y_reg    <= brick_y;
          lat_type_reg <= brick_type;
          lat_dir_reg  <= collideDir;
        end
        if (timeout_c)
          err_reg <= 1'b1;
      end
      if (state_reg == WR)
        lc_reg <= (remaining_c == 7'd0);
    end
  end

`ifdef SCORE_EN
  logic [15:0] score_reg;
  logic [7:0]  pts_c;
  logic [16:0] sum_c;

  always_comb begin
    pts_c = (lat_type_reg == 4'd3 || lat_type_reg == 4'd4) ? PTS_STRONG : PTS_NORMAL;
    sum_c = {1'b0, score_reg} + {9'd0, pts_c};
  end

  always_ff @(posedge clk) begin
    if (!resetn)
      score_reg <= 16'd0;
    else if (state_reg == WR && hit_reg)
      score_reg <= sum_c[16] ? 16'hFFFF : sum_c[15:0];
  end

  assign score = score_reg;
`else
  // Masked to zero; keeps the point values referenced when scoring is compiled out
  assign score = 16'd0 & {PTS_STRONG, PTS_NORMAL};
`endif

  assign ballcheckEnable = (state_reg == SCAN);
  assign ballcheckReset  = bcr_reg;
  assign wr_en           = (state_reg == WR) && hit_reg;
  assign wr_x            = wr_en ? lat_x_reg : 4'd0;
  assign wr_y            = wr_en ? lat_y_reg : 4'd0;
  assign wr_type         = wr_en ? wr_type_c : 4'd0;
  assign scan_done       = (state_reg == DONE);
  assign hit_valid       = scan_done && hit_reg;
  assign scan_err        = scan_done && err_reg;
  assign hit_dir         = lat_dir_reg;
  assign level_clear     = lc_reg;
  assign overrun         = frame_tick && (state_reg != IDLE);

endmodule

// File: tb/tb_brick_scan_controller.sv
// Table-driven bench for brick_scan_controller with a 9x9 behavioural brick scanner and level memory.
`timescale 1ns/1ps
module tb_brick_scan_controller;

  logic        clk = 1'b0;
  logic        resetn, frame_tick;
  logic        ballcheckEnable, ballcheckReset, ballcheckEnd, brickBallCollide;
  logic [2:0]  collideDir;
  logic [3:0]  brick_x, brick_y, brick_type;
  logic        wr_en;
  logic [3:0]  wr_x, wr_y, wr_type;
  logic        hit_valid, scan_done, scan_err, level_clear, overrun;
  logic [2:0]  hit_dir;
  logic [15:0] score;

  always #5 clk = ~clk;

  brick_scan_controller dut (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick),
    .ballcheckEnable(ballcheckEnable), .ballcheckReset(ballcheckReset), .ballcheckEnd(ballcheckEnd),
    .brickBallCollide(brickBallCollide), .collideDir(collideDir),
    .brick_x(brick_x), .brick_y(brick_y), .brick_type(brick_type),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_type(wr_type),
    .hit_valid(hit_valid), .hit_dir(hit_dir), .scan_done(scan_done), .scan_err(scan_err),
    .level_clear(level_clear), .overrun(overrun), .score(score)
  );

  // Scanner model: visits idx 0..80 (x = idx%9, y = idx/9) one per enabled cycle, then raises a sticky end
  int         idx;
  logic       end_f, stuck, valid;
  int         c1, c2;
  logic [2:0] d1, d2;
  logic [3:0] lvl [81];

  always_ff @(posedge clk) begin
    if (ballcheckReset) begin
      idx   <= 0;
      end_f <= 1'b0;
    end else if (ballcheckEnable && !end_f && idx < 81) begin
      if (idx == 80) end_f <= !stuck;
      idx <= idx + 1;
    end
  end

  always_comb begin
    valid            = ballcheckEnable && !end_f && (idx < 81);
    brick_x          = valid ? 4'(idx % 9) : 4'hF;
    brick_y          = valid ? 4'(idx / 9) : 4'h0;
    brick_type       = valid ? lvl[idx] : 4'h0;
    brickBallCollide = valid && (idx == c1 || idx == c2);
    collideDir       = (valid && idx == c1) ? d1 : (valid && idx == c2) ? d2 : 3'd4;
    ballcheckEnd     = end_f;
  end

  typedef struct {
    int red_lo, red_hi, sp_idx, sp_type, c1, d1, c2, d2, stuck, ovr_cyc;
    int exp_lat, exp_err, exp_wr, exp_wx, exp_wy, exp_wt, exp_hit, exp_dir, exp_clear, exp_pts;
  } vec_t;

  vec_t tbl [9];
  int   n_pass = 0, n_total = 0;
  int   score_exp = 0;

  task automatic chk(input string name, input int vi, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL v%0d %s: got %0h expected %0h", vi, name, act, exp);
    else n_pass++;
  endtask

  task automatic run_scan(input vec_t v, input int vi);
    int n, wr_cnt, wcyc;
    logic done, s_err, s_hit, s_clear;
    logic [2:0] s_dir;
    logic [3:0] wx, wy, wt;
    logic [15:0] s_score;
    for (int i = 0; i < 81; i++) lvl[i] = 4'd0;
    for (int i = v.red_lo; i <= v.red_hi; i++) lvl[i] = 4'd1;
    if (v.sp_idx >= 0) lvl[v.sp_idx] = 4'(v.sp_type);
    c1 = v.c1; c2 = v.c2; d1 = 3'(v.d1); d2 = 3'(v.d2); stuck = (v.stuck != 0);
    n = 0; wr_cnt = 0; wcyc = 0; done = 0;
    s_err = 0; s_hit = 0; s_clear = 0; s_dir = 0; s_score = 0; wx = 0; wy = 0; wt = 0;
    frame_tick = 1'b1;
    while (!done && n < 400) begin
      @(posedge clk); #1;
      n++;
      frame_tick = 1'b0;
      if (wr_en) begin
        wr_cnt++; wcyc = n; wx = wr_x; wy = wr_y; wt = wr_type;
      end
      if (scan_done) begin
        done = 1; s_err = scan_err; s_hit = hit_valid; s_dir = hit_dir;
        s_clear = level_clear; s_score = score;
      end
      if (v.ovr_cyc == n) begin
        frame_tick = 1'b1; #1;
        chk("overrun", vi, overrun, 1);
      end
    end
    if (!done) chk("scan_done_seen", vi, 0, 1);
`ifdef SCORE_EN
    score_exp += v.exp_pts;
`endif
    chk("latency", vi, n, v.exp_lat);
    chk("scan_err", vi, s_err, v.exp_err);
    chk("wr_count", vi, wr_cnt, v.exp_wr);
    if (v.exp_wr != 0) begin
      chk("wr_x", vi, wx, v.exp_wx);
      chk("wr_y", vi, wy, v.exp_wy);
      chk("wr_type", vi, wt, v.exp_wt);
      chk("wr_before_done", vi, wcyc, n - 1);
    end
    chk("hit_valid", vi, s_hit, v.exp_hit);
    chk("hit_dir", vi, s_dir, v.exp_dir);
    if (v.exp_err == 0) chk("level_clear", vi, s_clear, v.exp_clear);
    chk("score", vi, s_score, score_exp);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      frame_tick = 1'b0;
      chk("idle_reset", vi, ballcheckReset, 0);
      chk("idle_enable", vi, ballcheckEnable, 0);
    end
    $display("scan v%0d: lat=%0d err=%0d wr=%0d (%0d,%0d,t%0d) hit=%0d dir=%0d clear=%0d score=%0d",
             vi, n, s_err, wr_cnt, wx, wy, wt, s_hit, s_dir, s_clear, s_score);
  endtask

  initial begin
    // red_lo red_hi sp_idx sp_type c1 d1 c2 d2 stuck ovr | lat err wr wx wy wt hit dir clear pts
    tbl[0] = '{1, 0, -1, 0, -1, 0, -1, 0, 0, 0,    85, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    tbl[1] = '{1, 0, 21, 1, 21, 2, -1, 0, 0, 0,    85, 0, 1, 3, 2, 0, 1, 2, 1, 1};
    tbl[2] = '{76, 80, 0, 4, 0, 1, -1, 0, 0, 0,    85, 0, 1, 0, 0, 2, 1, 1, 0, 2};
    tbl[3] = '{10, 11, -1, 0, 10, 0, 11, 3, 0, 40, 85, 0, 1, 1, 1, 0, 1, 0, 0, 1};
    tbl[4] = '{1, 0, -1, 0, -1, 0, -1, 0, 1, 0,    202, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[5] = '{1, 0, 80, 3, 80, 1, -1, 0, 0, 85,   85, 0, 1, 8, 8, 1, 1, 1, 0, 2};
    tbl[6] = '{40, 40, -1, 0, -1, 0, -1, 0, 0, 0,  85, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    tbl[7] = '{1, 0, 47, 7, 47, 3, -1, 0, 0, 0,    85, 0, 1, 2, 5, 0, 1, 3, 1, 1};
    tbl[8] = '{0, 2, 40, 2, 40, 2, -1, 0, 0, 0,    85, 0, 1, 4, 4, 0, 1, 2, 0, 1};

    resetn = 1'b0; frame_tick = 1'b0; stuck = 1'b0; c1 = -1; c2 = -1; d1 = 0; d2 = 0;
    for (int i = 0; i < 81; i++) lvl[i] = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ballcheckReset", -1, ballcheckReset, 1);
    chk("rst_enable", -1, ballcheckEnable, 0);
    chk("rst_wr_en", -1, wr_en, 0);
    chk("rst_scan_done", -1, scan_done, 0);
    chk("rst_hit_valid", -1, hit_valid, 0);
    chk("rst_level_clear", -1, level_clear, 0);
    chk("rst_score", -1, score, 0);
    chk("rst_overrun", -1, overrun, 0);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_rst", -1, ballcheckReset, 0);

    for (int vi = 0; vi < 9; vi++) run_scan(tbl[vi], vi);

    // Reset in the middle of a full-level scan
    for (int i = 0; i < 81; i++) lvl[i] = 4'd1;
    c1 = -1; c2 = -1; stuck = 1'b0;
    frame_tick = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      frame_tick = 1'b0;
    end
    chk("midscan_enable_before", 9, ballcheckEnable, 1);
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("midrst_enable", 9, ballcheckEnable, 0);
    chk("midrst_ballcheckReset", 9, ballcheckReset, 1);
    chk("midrst_score", 9, score, 0);
    chk("midrst_hit_dir", 9, hit_dir, 0);
    chk("midrst_scan_done", 9, scan_done, 0);
    resetn = 1'b1;
    score_exp = 0;
    @(posedge clk); #1;
    chk("midrst_idle", 9, ballcheckReset, 0);
    run_scan(tbl[0], 10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
